// File: rtl/cap_pkg.sv
// rtl/cap_pkg.sv - shared opcodes, response codes, reset values and FSM states for cmd_cfg
package cap_pkg;

    typedef enum logic [3:0] {
        OP_DUMP      = 4'h1,
        OP_TRIG_TYPE = 4'h2,
        OP_TRIG_POS  = 4'h3,
        OP_DEC_PWR   = 4'h4,
        OP_READBACK  = 4'h5,
        OP_CLR_DONE  = 4'h6
    } opcode_e;

    typedef logic [8:0] address_t;

    localparam logic [7:0] RESP_ACK = 8'hA5;
    localparam logic [7:0] RESP_NAK = 8'hEE;

    localparam logic [1:0] TRIG_TYPE_RST = 2'b00;
    localparam address_t   TRIG_POS_RST  = 9'h100;
    localparam logic [3:0] DEC_PWR_RST   = 4'h0;
    localparam logic [3:0] DEC_PWR_MAX   = 4'd11;
    localparam logic [7:0] RESP_RST      = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_RESP_WAIT,
        ST_DUMP_WAIT,
        ST_DUMP_TX
    } state_e;

    function automatic logic [7:0] readback_byte(
        input logic [1:0] sel,
        input logic [1:0] trig_type,
        input address_t   trig_pos,
        input logic [3:0] dec_pwr,
        input logic       capture_done
    );
        case (sel)
            2'd0:    readback_byte = {6'b0, trig_type};
            2'd1:    readback_byte = trig_pos[7:0];
            2'd2:    readback_byte = {7'b0, trig_pos[8]};
            default: readback_byte = {capture_done, 3'b0, dec_pwr};
        endcase
    endfunction

endpackage

// File: rtl/cfg_regs.sv
// rtl/cfg_regs.sv - capture configuration registers and capture_done flag
module cfg_regs
    import cap_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_trig_type,
    input  logic       wr_trig_pos,
    input  logic       wr_dec_pwr,
    input  logic       clr_capture_done,
    input  logic       set_capture_done,
    input  address_t   wdata,
    output logic [1:0] trig_type,
    output address_t   trig_pos,
    output logic [3:0] dec_pwr,
    output logic       capture_done
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_type    <= TRIG_TYPE_RST;
            trig_pos     <= TRIG_POS_RST;
            dec_pwr      <= DEC_PWR_RST;
            capture_done <= 1'b0;
        end else begin
            if (wr_trig_type) trig_type <= wdata[1:0];
            if (wr_trig_pos)  trig_pos  <= wdata;
            if (wr_dec_pwr)   dec_pwr   <= wdata[3:0];
            // a capture finishing in the same cycle as a host clear must not be lost
            if (set_capture_done)
                capture_done <= 1'b1;
            else if (clr_capture_done)
                capture_done <= 1'b0;
        end
    end

endmodule

// File: rtl/cmd_cfg.sv
// rtl/cmd_cfg.sv - host command decoder and dump sequencer; CMD_CFG_READBACK_EN enables opcode 0x5 readback
module cmd_cfg
    import cap_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cmd,
    input  logic        cmd_rdy,
    output logic        clr_cmd_rdy,
    output logic [7:0]  resp,
    output logic        send_resp,
    input  logic        resp_sent,
    output logic [1:0]  trig_type,
    output logic [8:0]  trig_pos,
    output logic [3:0]  dec_pwr,
    output logic        capture_done,
    input  logic        set_capture_done,
    output logic        start_dump,
    input  logic        send_dump,
    input  logic [7:0]  dump_data,
    output logic        dump_sent,
    input  logic        dump_finished
);

    state_e     state_q, state_d;
    logic [3:0] op_q;
    address_t   payload_q;
    logic [7:0] resp_q, resp_d;
    logic       latch_cmd;
    logic       wr_trig_type, wr_trig_pos, wr_dec_pwr, clr_done;
    logic       unused_cmd_bits;

    assign unused_cmd_bits = ^cmd[11:9];

    cfg_regs u_cfg_regs (
        .clk              (clk),
        .rst_n            (rst_n),
        .wr_trig_type     (wr_trig_type),
        .wr_trig_pos      (wr_trig_pos),
        .wr_dec_pwr       (wr_dec_pwr),
        .clr_capture_done (clr_done),
        .set_capture_done (set_capture_done),
        .wdata            (payload_q),
        .trig_type        (trig_type),
        .trig_pos         (trig_pos),
        .dec_pwr          (dec_pwr),
        .capture_done     (capture_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            op_q      <= 4'h0;
            payload_q <= '0;
            resp_q    <= RESP_RST;
        end else begin
            state_q <= state_d;
            resp_q  <= resp_d;
            if (latch_cmd) begin
                op_q      <= cmd[15:12];
                payload_q <= cmd[8:0];
            end
        end
    end

    // resp_d only departs from resp_q alongside send_resp, so resp is valid in the pulse cycle and held after
    assign resp = resp_d;

    always_comb begin
        state_d      = state_q;
        resp_d       = resp_q;
        latch_cmd    = 1'b0;
        clr_cmd_rdy  = 1'b0;
        send_resp    = 1'b0;
        start_dump   = 1'b0;
        dump_sent    = 1'b0;
        wr_trig_type = 1'b0;
        wr_trig_pos  = 1'b0;
        wr_dec_pwr   = 1'b0;
        clr_done     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_rdy) begin
                    clr_cmd_rdy = 1'b1;
                    latch_cmd   = 1'b1;
                    state_d     = ST_DECODE;
                end
            end
            ST_DECODE: begin
                send_resp = 1'b1;
                resp_d    = RESP_NAK;
                state_d   = ST_RESP_WAIT;
                case (op_q)
                    OP_DUMP: begin
                        if (capture_done) begin
                            send_resp  = 1'b0;
                            resp_d     = resp_q;
                            start_dump = 1'b1;
                            state_d    = ST_DUMP_WAIT;
                        end
                    end
                    OP_TRIG_TYPE: begin
                        wr_trig_type = 1'b1;
                        resp_d       = RESP_ACK;
                    end
                    OP_TRIG_POS: begin
                        wr_trig_pos = 1'b1;
                        resp_d      = RESP_ACK;
                    end
                    OP_DEC_PWR: begin
                        if (payload_q[3:0] <= DEC_PWR_MAX) begin
                            wr_dec_pwr = 1'b1;
                            resp_d     = RESP_ACK;
                        end
                    end
`ifdef CMD_CFG_READBACK_EN
                    OP_READBACK: begin
                        resp_d = readback_byte(payload_q[1:0], trig_type, trig_pos,
                                               dec_pwr, capture_done);
                    end
`endif
                    OP_CLR_DONE: begin
                        clr_done = 1'b1;
                        resp_d   = RESP_ACK;
                    end
                    default: ;
                endcase
            end
            ST_RESP_WAIT: begin
                if (resp_sent) state_d = ST_IDLE;
            end
            ST_DUMP_WAIT: begin
                if (send_dump) begin
                    resp_d    = dump_data;
                    send_resp = 1'b1;
                    state_d   = ST_DUMP_TX;
                end
            end
            ST_DUMP_TX: begin
                if (resp_sent) begin
                    dump_sent = 1'b1;
                    state_d   = dump_finished ? ST_IDLE : ST_DUMP_WAIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_cmd_cfg.sv
// tb/tb_cmd_cfg.sv - scoreboard bench for cmd_cfg; expectations follow CMD_CFG_READBACK_EN
module tb_cmd_cfg;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] cmd = '0;
    logic        cmd_rdy = 1'b0;
    logic        clr_cmd_rdy;
    logic [7:0]  resp;
    logic        send_resp;
    logic        resp_sent = 1'b0;
    logic [1:0]  trig_type;
    logic [8:0]  trig_pos;
    logic [3:0]  dec_pwr;
    logic        capture_done;
    logic        set_capture_done = 1'b0;
    logic        start_dump;
    logic        send_dump = 1'b0;
    logic [7:0]  dump_data = '0;
    logic        dump_sent;
    logic        dump_finished = 1'b0;

    int checks = 0;
    int failures = 0;
    int n_clr = 0, n_start = 0, n_dump_sent = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    cmd_cfg dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cmd              (cmd),
        .cmd_rdy          (cmd_rdy),
        .clr_cmd_rdy      (clr_cmd_rdy),
        .resp             (resp),
        .send_resp        (send_resp),
        .resp_sent        (resp_sent),
        .trig_type        (trig_type),
        .trig_pos         (trig_pos),
        .dec_pwr          (dec_pwr),
        .capture_done     (capture_done),
        .set_capture_done (set_capture_done),
        .start_dump       (start_dump),
        .send_dump        (send_dump),
        .dump_data        (dump_data),
        .dump_sent        (dump_sent),
        .dump_finished    (dump_finished)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rb(input logic [7:0] v);
`ifdef CMD_CFG_READBACK_EN
        return v;
`else
        return 8'hEE;
`endif
    endfunction

    // scoreboard consumer and pulse counters, sampled away from the active edge
    always @(negedge clk) begin
        if (clr_cmd_rdy) n_clr++;
        if (start_dump)  n_start++;
        if (dump_sent)   n_dump_sent++;
        if (send_resp) begin
            if (exp_q.size() == 0) check("unexpected_send_resp", 1, 0);
            else check("resp", resp, exp_q.pop_front());
        end
    end

    task automatic do_cmd(input logic [15:0] c, input bit has_resp, input logic [7:0] e,
                          input bit set_in_decode);
        bit seen;
        if (has_resp) exp_q.push_back(e);
        @(posedge clk); #1;
        cmd = c;
        cmd_rdy = 1'b1;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (clr_cmd_rdy) seen = 1;
        end
        if (!seen) check("clr_cmd_rdy_timeout", 0, 1);
        @(posedge clk); #1;
        cmd_rdy = 1'b0;
        set_capture_done = set_in_decode;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (send_resp || start_dump) seen = 1;
            @(posedge clk); #1;
            set_capture_done = 1'b0;
        end
        if (!seen) check("decode_timeout", 0, 1);
        if (has_resp) begin
            resp_sent = 1'b1;
            @(posedge clk); #1;
            resp_sent = 1'b0;
        end
    endtask

    // sends one dump byte and leaves the DUT in DUMP_TX awaiting resp_sent
    task automatic dump_byte(input logic [7:0] b);
        exp_q.push_back(b);
        send_dump = 1'b1;
        dump_data = b;
        @(posedge clk); #1;
        send_dump = 1'b0;
    endtask

    task automatic ack_dump(input bit last);
        resp_sent = 1'b1;
        dump_finished = last;
        @(posedge clk); #1;
        resp_sent = 1'b0;
        dump_finished = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check("rst_trig_type", trig_type, 2'b00);
        check("rst_trig_pos", trig_pos, 9'h100);
        check("rst_dec_pwr", dec_pwr, 4'h0);
        check("rst_capture_done", capture_done, 0);
        check("rst_resp", resp, 8'h00);
        check("rst_pulses", {clr_cmd_rdy, send_resp, start_dump, dump_sent}, 4'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        do_cmd(16'h3055, 1, 8'hA5, 0);
        check("trig_pos_055", trig_pos, 9'h055);
        check("clr_pulse_count", n_clr, 1);

        do_cmd(16'h400C, 1, 8'hEE, 0);
        check("dec_pwr_unchanged", dec_pwr, 4'h0);
        do_cmd(16'h400B, 1, 8'hA5, 0);
        check("dec_pwr_b", dec_pwr, 4'hB);

        do_cmd(16'h2003, 1, 8'hA5, 0);
        check("trig_type_3", trig_type, 2'd3);
        do_cmd(16'h7000, 1, 8'hEE, 0);
        do_cmd(16'hF123, 1, 8'hEE, 0);

        do_cmd(16'h1000, 1, 8'hEE, 0);
        check("no_start_dump", n_start, 0);

        @(posedge clk); #1;
        set_capture_done = 1'b1;
        @(posedge clk); #1;
        set_capture_done = 1'b0;
        check("capture_done_set", capture_done, 1);
        do_cmd(16'h2000, 1, 8'hA5, 0);
        check("trig_type_0", trig_type, 2'd0);
        check("capture_done_kept", capture_done, 1);

        do_cmd(16'h31A0, 1, 8'hA5, 0);
        do_cmd(16'h5002, 1, rb(8'h01), 0);
        do_cmd(16'h5001, 1, rb(8'hA0), 0);
        do_cmd(16'h5003, 1, rb(8'h8B), 0);
        do_cmd(16'h5000, 1, rb(8'h00), 0);

        do_cmd(16'h1000, 0, 8'h00, 0);
        check("start_dump_count", n_start, 1);
        dump_byte(8'h11); ack_dump(0);
        dump_byte(8'h22); ack_dump(0);
        dump_byte(8'h33); ack_dump(1);
        check("dump_sent_count", n_dump_sent, 3);
        check("resp_held", resp, 8'h33);

        do_cmd(16'h6000, 1, 8'hA5, 0);
        check("capture_done_clr", capture_done, 0);
        do_cmd(16'h6000, 1, 8'hA5, 1);
        check("set_wins", capture_done, 1);

        do_cmd(16'h1000, 0, 8'h00, 0);
        dump_byte(8'h44);
        rst_n = 1'b0;
        #2;
        check("mid_rst_trig_pos", trig_pos, 9'h100);
        check("mid_rst_capture_done", capture_done, 0);
        check("mid_rst_resp", resp, 8'h00);
        check("mid_rst_pulses", {clr_cmd_rdy, send_resp, start_dump, dump_sent}, 4'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        ack_dump(0);
        repeat (2) @(posedge clk);
        check("no_dump_sent_after_rst", n_dump_sent, 3);

        do_cmd(16'h3055, 1, 8'hA5, 0);
        check("trig_pos_after_rst", trig_pos, 9'h055);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cmd_cfg.md
CMD_CFG -- requirements
Module: cmd_cfg

Interface
REQ-001 SHALL provide: clk  in  1  system clock.
REQ-002 SHALL provide: rst_n  in  1  reset; one clock, reset asynchronous and active-low.
REQ-003 SHALL provide: cmd  in  16  host command word (opcode cmd[15:12], payload cmd[8:0]).
REQ-004 SHALL provide: cmd_rdy  in  1  cmd valid, held until cleared; clr_cmd_rdy  out  1  one-cycle pulse consuming cmd.
REQ-005 SHALL provide: resp  out  8  byte to host; send_resp  out  1  one-cycle transmit pulse; resp_sent  in  1  transmit-complete pulse.
REQ-006 SHALL provide: trig_type  out  2; trig_pos  out  9; dec_pwr  out  4  capture configuration registers.
REQ-007 SHALL provide: capture_done  out  1; set_capture_done  in  1  capture-complete strobe from the capture engine.
REQ-008 SHALL provide: start_dump  out  1 pulse; send_dump  in  1; dump_data  in  8  sample RAM output; dump_sent  out  1 pulse; dump_finished  in  1.

Function
REQ-009 SHALL implement states IDLE, DECODE, RESP_WAIT, DUMP_WAIT, DUMP_TX; unknown state -> IDLE.
REQ-010 IDLE with cmd_rdy=1 SHALL pulse clr_cmd_rdy, latch cmd and enter DECODE next cycle.
REQ-011 DECODE SHALL take exactly one cycle, drive resp, pulse send_resp and enter RESP_WAIT, except the dump opcode when accepted.
REQ-012 Opcodes: 0x1 dump; 0x2 write trig_type=cmd[1:0]; 0x3 write trig_pos=cmd[8:0]; 0x4 write dec_pwr=cmd[3:0]; 0x5 readback; 0x6 clear capture_done; all others NAK.
REQ-013 Successful writes and clears SHALL update the register in the DECODE cycle and respond ACK=8'hA5.
REQ-014 Opcode 0x4 with cmd[3:0]>4'd11 SHALL respond NAK=8'hEE and leave dec_pwr unchanged.
REQ-015 Opcode 0x1 with capture_done=0 SHALL respond NAK; with capture_done=1 SHALL pulse start_dump and enter DUMP_WAIT without responding.
REQ-016 RESP_WAIT SHALL hold until resp_sent, then return to IDLE; cmd_rdy SHALL be ignored outside IDLE.
REQ-017 DUMP_WAIT with send_dump=1 SHALL drive resp=dump_data, pulse send_resp and enter DUMP_TX.
REQ-018 DUMP_TX on resp_sent SHALL pulse dump_sent; same-cycle dump_finished=1 -> IDLE, else -> DUMP_WAIT.
REQ-019 resp SHALL hold its value from the send_resp cycle until the next send_resp.
REQ-020 capture_done SHALL set on set_capture_done and clear on opcode 0x6; when both occur in one cycle, set SHALL win.
REQ-021 Writing trig_type=0 SHALL not alter capture_done.
REQ-022 All pulses SHALL be exactly one cycle and never coincide with a state other than the one specified.

Reset
REQ-023 rst_n low SHALL asynchronously force IDLE, trig_type=2'b00, trig_pos=9'h100, dec_pwr=4'h0, capture_done=0, resp=8'h00, all pulse outputs 0.
REQ-024 Reset asserted mid-dump SHALL abandon the dump with no further dump_sent.

Configuration
REQ-025 Macro CMD_CFG_READBACK_EN defined: opcode 0x5 SHALL respond with the register selected by cmd[1:0] (0 {6'b0,trig_type}, 1 trig_pos[7:0], 2 {7'b0,trig_pos[8]}, 3 {capture_done,3'b0,dec_pwr}).
REQ-026 Macro undefined: opcode 0x5 SHALL respond NAK and no readback logic SHALL exist.

Structure
REQ-027 Shared package cap_pkg SHALL hold the opcode enum, ACK/NAK constants, the 9-bit Address typedef and reset constants.
REQ-028 Configuration registers plus capture_done flag SHALL be one sub-module cfg_regs; FSM stays in cmd_cfg.

Verification
REQ-029 Reset then cmd=16'h3055 -> clr_cmd_rdy pulse, trig_pos=9'h055 after DECODE, resp=8'hA5 with send_resp.
REQ-030 cmd=16'h400C -> resp=8'hEE, dec_pwr stays 0; cmd=16'h400B -> ACK, dec_pwr=4'hB.
REQ-031 capture_done=0, cmd=16'h1000 -> NAK, no start_dump; after set_capture_done, cmd=16'h1000 -> start_dump pulse, three send_dump/dump_data bytes 8'h11/22/33 echoed on resp, third with dump_finished -> IDLE.
REQ-032 set_capture_done and decode of cmd=16'h6000 same cycle -> capture_done=1, resp ACK.
REQ-033 With CMD_CFG_READBACK_EN, after trig_pos=9'h1A0, cmd=16'h5002 -> resp=8'h01; without macro -> resp=8'hEE.
REQ-034 rst_n low during DUMP_TX -> IDLE, outputs at reset values, next resp_sent produces no dump_sent.
